// File: rtl/cart_capture_pkg.sv
// cart_capture_pkg: shared types and constants for the cartridge-bus burst capture block
package cart_capture_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } packet_t;
  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, RD_HI, RD_LO} cap_state_t;
  localparam logic [31:0] CART_ADDR_INC = 32'd4;
endpackage

// File: rtl/cart_capture_fifo.sv
// cart_capture_fifo: synchronous packet FIFO with full/empty flags and simultaneous push/pop
//   clk, reset  : clock and synchronous active-high reset
//   i_push      : write i_data; ignored when full unless i_pop pops in the same cycle
//   i_pop       : drop the head entry; ignored when empty
//   o_data      : head entry, zero while empty
//   o_full      : all entries occupied
//   o_empty     : no entries
module cart_capture_fifo
  import cart_capture_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_push,
  input  packet_t i_data,
  input  logic    i_pop,
  output packet_t o_data,
  output logic    o_full,
  output logic    o_empty
);
  localparam int AW = $clog2(DEPTH);
  packet_t r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;
  // The extra pointer bit tells a full FIFO apart from an empty one when the indices match.
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || i_pop);
  assign o_data = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/cart_burst_capture.sv
// cart_burst_capture: passive N64 PI-bus burst read capture into a ready/valid FIFO
//   clk, reset                 : clock and synchronous active-high reset
//   cart_ad/alel/aleh/rd       : asynchronous cartridge bus pins (rd active low)
//   addr_o, data_o, valid_o    : FIFO head entry, accepted when valid_o && ready_i
//   ready_i                    : consumer ready
//   burst_len_o                : word count of the last completed burst, saturating at 255
//   overflow_o                 : sticky, a word was dropped on a full FIFO
//   err_o                      : sticky, [0] partial word, [1] burst longer than MAX_BURST_WORDS
//   CART_BURST_CAPTURE_FILTER_EN: when defined, only bursts starting inside FILTER_BASE/FILTER_MASK are captured
module cart_burst_capture
  import cart_capture_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 16,
  parameter int          MAX_BURST_WORDS = 128,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [31:0] FILTER_BASE     = 32'h1000_0000,
  parameter logic [31:0] FILTER_MASK     = 32'hFFF0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cart_ad,
  input  logic        cart_alel,
  input  logic        cart_aleh,
  input  logic        cart_rd,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [7:0]  burst_len_o,
  output logic        overflow_o,
  output logic [1:0]  err_o
);
  logic [18:0] r_sync [SYNC_STAGES];
  logic [2:0] r_prev;
  logic [18:0] w_s;
  logic [15:0] w_ad;
  logic w_aleh_rise, w_aleh_fall, w_alel_fall, w_rd_rise;
  cap_state_t r_state, w_next;
  logic w_lat_hi, w_lat_lo, w_rd_hi, w_word, w_end, w_partial;
  logic [31:0] r_addr, r_cnt;
  logic [15:0] r_hi;
  logic r_cap, r_ovf, w_match, w_below, w_push, w_full, w_empty;
  logic [7:0] r_len;
  logic [1:0] r_err;
  packet_t w_head;
  // Data travels through the same synchroniser as the strobes so it stays aligned with them.
  assign w_s = r_sync[SYNC_STAGES-1];
  assign w_ad = w_s[18:3];
  assign w_aleh_rise = w_s[2] && !r_prev[2];
  assign w_aleh_fall = !w_s[2] && r_prev[2];
  assign w_alel_fall = !w_s[1] && r_prev[1];
  assign w_rd_rise = w_s[0] && !r_prev[0];
`ifdef CART_BURST_CAPTURE_FILTER_EN
  assign w_match = ({r_addr[31:16], w_ad} & FILTER_MASK) == FILTER_BASE;
`else
  logic w_unused_filter;
  assign w_unused_filter = ^{FILTER_BASE, FILTER_MASK};
  assign w_match = 1'b1;
`endif
  assign w_below = r_cnt < MAX_BURST_WORDS;
  assign w_push = w_word && r_cap && w_below;
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_lat_hi = 1'b0;
    w_lat_lo = 1'b0;
    w_rd_hi = 1'b0;
    w_word = 1'b0;
    w_end = 1'b0;
    w_partial = 1'b0;
    case (r_state)
      IDLE: w_next = w_aleh_rise ? ADDR_H : IDLE;
      ADDR_H: begin
        w_lat_hi = w_aleh_fall;
        w_next = w_aleh_fall ? ADDR_L : ADDR_H;
      end
      ADDR_L: begin
        w_lat_lo = !w_aleh_rise && w_alel_fall;
        w_next = w_aleh_rise ? ADDR_H : w_alel_fall ? RD_HI : ADDR_L;
      end
      RD_HI: begin
        w_end = w_aleh_rise;
        w_rd_hi = !w_aleh_rise && w_rd_rise;
        w_next = w_aleh_rise ? ADDR_H : w_rd_rise ? RD_LO : RD_HI;
      end
      RD_LO: begin
        w_end = w_aleh_rise;
        w_partial = w_aleh_rise;
        w_word = !w_aleh_rise && w_rd_rise;
        w_next = w_aleh_rise ? ADDR_H : w_rd_rise ? RD_HI : RD_LO;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
      r_addr <= '0;
      r_hi <= '0;
      r_cnt <= '0;
      r_cap <= 1'b0;
      r_len <= '0;
      r_ovf <= 1'b0;
      r_err <= '0;
    end else begin
      r_sync[0] <= {cart_ad, cart_aleh, cart_alel, cart_rd};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s[2:0];
      if (w_lat_hi) r_addr[31:16] <= w_ad;
      if (w_lat_lo) begin
        r_addr[15:0] <= w_ad;
        r_cnt <= '0;
        r_cap <= w_match;
      end
      if (w_rd_hi) r_hi <= w_ad;
      // Address and count advance for every word, even ones past the burst limit.
      if (w_word) begin
        r_addr <= r_addr + CART_ADDR_INC;
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_end) r_len <= (r_cnt > 32'd255) ? 8'hFF : r_cnt[7:0];
      if (w_partial && r_cap) r_err[0] <= 1'b1;
      if (w_word && r_cap && !w_below) r_err[1] <= 1'b1;
      if (w_push && w_full && !ready_i) r_ovf <= 1'b1;
    end
  end
  cart_capture_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_data({r_addr, r_hi, w_ad}),
    .i_pop(ready_i),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign valid_o = !w_empty;
  assign addr_o = w_head.addr;
  assign data_o = w_head.data;
  assign burst_len_o = r_len;
  assign overflow_o = r_ovf;
  assign err_o = r_err;
endmodule

// File: doc/cart_burst_capture.md
# cart_burst_capture

Passive capture of the N64 cartridge (PI) bus, generalised from single 32-bit reads to multi-word burst reads with address auto-increment and a buffered ready/valid output. Sits between the cartridge-bus pins and the capture/streaming logic. Each completed 32-bit word becomes one `{addr, data}` entry in an internal FIFO. Bus pins are asynchronous to `clk` and are synchronised internally.

## Interface
- `FIFO_DEPTH`, 16: output FIFO entries; power of two, ≥2.
- `MAX_BURST_WORDS`, 128: words accepted per address phase; further words are dropped and flagged.
- `SYNC_STAGES`, 2: synchroniser flops on every bus input, ≥2.
- `FILTER_BASE`, 32'h1000_0000: address window base (used only with the filter macro).
- `FILTER_MASK`, 32'hFFF0_0000: address window mask (used only with the filter macro).

Ports:
- `clk` in 1: system clock; the block's only clock.
- `reset` in 1: synchronous, active-high reset.
- `cart_ad` in 16: multiplexed address/data bus.
- `cart_alel` in 1: address-latch-low strobe.
- `cart_aleh` in 1: address-latch-high strobe.
- `cart_rd` in 1: read strobe, active low.
- `addr_o` out 32: address of the word at the FIFO head.
- `data_o` out 32: word at the FIFO head.
- `valid_o` out 1: head entry valid.
- `ready_i` in 1: consumer accepts the head entry when `valid_o && ready_i`.
- `burst_len_o` out 8: word count of the last completed burst, saturating at 255.
- `overflow_o` out 1: sticky; a word was dropped because the FIFO was full.
- `err_o` out 2: sticky. Bit 0 is set by a partial word (odd halfword count). Bit 1 is set when a burst exceeds `MAX_BURST_WORDS`.

## Operation
- All bus inputs pass through `SYNC_STAGES` flops. `cart_ad` is delayed by the same amount so it stays aligned with the strobes. Edge detection uses one further flop.
- FSM states and transitions:
  - IDLE: on rising `aleh` go to ADDR_H.
  - ADDR_H: on falling `aleh`, latch `addr[31:16]`, go to ADDR_L.
  - ADDR_L: on falling `alel`, latch `addr[15:0]`, clear the word counter, go to RD_HI.
  - RD_HI: on rising `cart_rd`, latch the halfword into `data[31:16]`, go to RD_LO.
  - RD_LO: on rising `cart_rd`, latch `data[15:0]`, push `{addr, data}`, add 4 to `addr` (wraps modulo 2^32), increment the counter, go to RD_HI.
- From RD_HI or RD_LO, a rising `aleh` ends the burst. `burst_len_o` updates and the FSM goes to ADDR_H. If this happens in RD_LO, the half word is discarded and `err_o[0]` is set.
- A rising `aleh` seen in ADDR_L restarts in ADDR_H.
- A rising `cart_rd` in IDLE, ADDR_H or ADDR_L is ignored.
- Once the counter reaches `MAX_BURST_WORDS`, further words are not pushed, `err_o[1]` is set, and address increment continues.
- If the FIFO is full at push time and there is no simultaneous pop, the word is dropped and `overflow_o` is set. A push and pop in the same cycle on a full FIFO succeed.
- Reset values: FSM IDLE, FIFO empty, `valid_o`=0, `addr_o`=`data_o`=0, `burst_len_o`=0, `overflow_o`=0, `err_o`=0. A reset mid-burst discards the partial word and all FIFO contents.

## Timing
- Pin edge to FSM action: `SYNC_STAGES`+1 cycles.
- A push in cycle N gives `valid_o`=1 in cycle N+1, with registered outputs.
- A pop in cycle N means the next entry, if any, is presented in N+1. Back-to-back pops sustain 1 word per cycle.
- `addr_o` and `data_o` are stable while `valid_o && !ready_i`.
- Bus strobe pulses must be ≥ `SYNC_STAGES`+1 `clk` periods wide. The minimum bus halfword period is 2×(`SYNC_STAGES`+1) cycles.

## Configuration
- `CART_BURST_CAPTURE_FILTER_EN` defined: a burst whose latched start address satisfies `(addr & FILTER_MASK) == FILTER_BASE` is captured. Any other burst is tracked by the FSM, but none of its words are pushed and no errors are flagged.
- Macro undefined: every burst is captured, and `FILTER_BASE` and `FILTER_MASK` are unused.

## Structure
- Package `cart_capture_pkg` holds:
  - `packet_t` (addr, data: 32 bits each),
  - the FSM state enum `cap_state_t`,
  - `CART_ADDR_INC` = 4.
- Sub-module `cart_capture_fifo`: a synchronous FIFO of `packet_t` with full/empty flags, pointer wrap handling, and simultaneous push/pop.

## Test plan
- Single read at 0x1000_0000 returning 0x1240_0037 → one entry {0x1000_0000, 0x1240_0037}, `burst_len_o`=1.
- Burst of 3 words at 0x1000_0040 (ABCD_1234, A5B9_0102, 7788_9900) → addresses 0x40, 0x44, 0x48 with matching data; `burst_len_o`=3.
- `ready_i`=0 during a burst of `FIFO_DEPTH`+2 words:
  - the first `FIFO_DEPTH` words are retained in order,
  - `overflow_o`=1,
  - after draining, exactly `FIFO_DEPTH` entries are seen.
- Burst of 3 halfwords, then a new address phase → 1 entry, `err_o[0]`=1; the next burst captures normally.
- With the macro defined: bursts at 0x1000_0000 and 0x2000_0000 → only the 0x1000_0000 words appear. With the macro undefined, both appear.
- Reset asserted in RD_LO of a burst:
  - outputs return to their reset values,
  - FIFO is empty,
  - a following single read at 0xFFFF_FFFC captures correctly.
  - A 2-word burst at 0xFFFF_FFFC wraps its second address to 0x0000_0000.
